// File: rtl/dispatch_unit.sv
// Single-entry dispatch stage: holds one decoded instruction and offers it to the
// ALU/LSQ/BRA reservation station it targets, allocating a ROB entry on handoff.

module dispatch_slot (
  input  logic sel,
  input  logic en,
  input  logic ready,
  output logic valid,
  output logic fire
);
  assign valid = sel && en;
  assign fire  = valid && ready;
endmodule

module dispatch_unit #(
  parameter int PAYLOAD_W = 64,
  parameter int ROB_TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic                 dec_rob_en,
  input  logic [2:0]           dec_fu_type,
  input  logic [31:0]          dec_pc,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  input  logic                 rob_alloc_ready,
  input  logic [ROB_TAG_W-1:0] rob_alloc_tag,
  output logic                 rob_alloc_valid,
  output logic                 alu_valid,
  output logic                 lsq_valid,
  output logic                 bra_valid,
  input  logic                 alu_ready,
  input  logic                 lsq_ready,
  input  logic                 bra_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          out_pc,
  output logic [ROB_TAG_W-1:0] out_rob_tag,
  output logic [31:0]          dispatch_cnt,
  output logic [31:0]          stall_cnt,
  output logic [15:0]          illegal_cnt
);
  localparam int NUM_FU = 3;

  typedef enum logic {EMPTY, HELD} state_e;

  typedef struct packed {
    logic [NUM_FU-1:0]    fu;
    logic [31:0]          pc;
    logic [PAYLOAD_W-1:0] payload;
  } hold_t;

  state_e      state_q, state_d;
  hold_t       hold_q, hold_d;
  logic [31:0] dispatch_cnt_q, dispatch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  logic [NUM_FU-1:0] fu_ready, fu_valid, fu_fire;
  logic              offer_en, fire, accept, legal;

  // rst and flush gate every handshake output in the same cycle
  assign offer_en = (state_q == HELD) && rob_alloc_ready && !flush && !rst;
  assign fu_ready = {bra_ready, lsq_ready, alu_ready};

  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    dispatch_slot u_slot (
      .sel   (hold_q.fu[g]),
      .en    (offer_en),
      .ready (fu_ready[g]),
      .valid (fu_valid[g]),
      .fire  (fu_fire[g])
    );
  end

  assign fire      = |fu_fire;
  assign dec_ready = !rst && !flush && ((state_q == EMPTY) || fire);
  assign accept    = dec_valid && dec_ready;
  assign legal     = dec_rob_en && (dec_fu_type == 3'b001 || dec_fu_type == 3'b010 ||
                                    dec_fu_type == 3'b100);

  assign alu_valid       = fu_valid[0];
  assign lsq_valid       = fu_valid[1];
  assign bra_valid       = fu_valid[2];
  assign rob_alloc_valid = fire;
  assign out_rob_tag     = rob_alloc_tag;
  assign out_pc          = hold_q.pc;
  assign out_payload     = hold_q.payload;
  assign dispatch_cnt    = dispatch_cnt_q;
  assign stall_cnt       = stall_cnt_q;
  assign illegal_cnt     = illegal_cnt_q;

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    dispatch_cnt_d = dispatch_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    illegal_cnt_d  = illegal_cnt_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      if (fire) state_d = EMPTY;
      if (accept && legal) begin
        state_d = HELD;
        hold_d  = '{fu: dec_fu_type, pc: dec_pc, payload: dec_payload};
      end
      if (accept && !legal) illegal_cnt_d = illegal_cnt_q + 16'd1;
      if (fire) dispatch_cnt_d = dispatch_cnt_q + 32'd1;
      else if (state_q == HELD) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      hold_q         <= '0;
      dispatch_cnt_q <= '0;
      stall_cnt_q    <= '0;
      illegal_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      dispatch_cnt_q <= dispatch_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      illegal_cnt_q  <= illegal_cnt_d;
    end
  end
endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: hand-computed expectations for reset, streaming,
// stalls, illegal drops, flush and mid-stall reset.

module tb_dispatch_unit;
  logic        clk = 0;
  logic        rst, flush, dec_valid, dec_ready, dec_rob_en;
  logic [2:0]  dec_fu_type;
  logic [31:0] dec_pc;
  logic [63:0] dec_payload;
  logic        rob_alloc_ready, rob_alloc_valid;
  logic [4:0]  rob_alloc_tag;
  logic        alu_valid, lsq_valid, bra_valid, alu_ready, lsq_ready, bra_ready;
  logic [63:0] out_payload;
  logic [31:0] out_pc;
  logic [4:0]  out_rob_tag;
  logic [31:0] dispatch_cnt, stall_cnt;
  logic [15:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dispatch_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rob_en(dec_rob_en), .dec_fu_type(dec_fu_type), .dec_pc(dec_pc),
    .dec_payload(dec_payload), .rob_alloc_ready(rob_alloc_ready),
    .rob_alloc_tag(rob_alloc_tag), .rob_alloc_valid(rob_alloc_valid),
    .alu_valid(alu_valid), .lsq_valid(lsq_valid), .bra_valid(bra_valid),
    .alu_ready(alu_ready), .lsq_ready(lsq_ready), .bra_ready(bra_ready),
    .out_payload(out_payload), .out_pc(out_pc), .out_rob_tag(out_rob_tag),
    .dispatch_cnt(dispatch_cnt), .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] fu, input logic [31:0] pc, input logic [63:0] pl);
    dec_valid = 1; dec_rob_en = 1; dec_fu_type = fu; dec_pc = pc; dec_payload = pl;
  endtask

  logic [2:0]  s_fu [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [31:0] s_pc [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100c};

  initial begin
    rst = 1; flush = 1; dec_valid = 1; dec_rob_en = 1; dec_fu_type = 3'b001;
    dec_pc = 32'h55; dec_payload = 64'h55; rob_alloc_ready = 1; rob_alloc_tag = 5'd3;
    alu_ready = 1; lsq_ready = 1; bra_ready = 1;
    #1;
    chk("rst_dec_ready", dec_ready, 0);
    chk("rst_alloc", rob_alloc_valid, 0);
    step();
    step();
    chk("rst_dispatch_cnt", dispatch_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_alu_valid", alu_valid, 0);
    rst = 0; flush = 0;

    // basic single dispatch
    present(3'b001, 32'h100, 64'hAAAA);
    #1 chk("t1_dec_ready", dec_ready, 1);
    chk("t1_alu_empty", alu_valid, 0);
    step();
    dec_valid = 0;
    #1 chk("t1_alu_valid", alu_valid, 1);
    chk("t1_out_pc", out_pc, 32'h100);
    chk("t1_out_tag", out_rob_tag, 5'd3);
    chk("t1_alloc", rob_alloc_valid, 1);
    chk("t1_payload", out_payload, 64'hAAAA);
    step();
    chk("t1_dispatch_cnt", dispatch_cnt, 1);
    chk("t1_empty_alu", alu_valid, 0);

    // back-to-back stream
    present(s_fu[0], s_pc[0], 64'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) present(s_fu[i+1], s_pc[i+1], 64'(i + 1));
      else dec_valid = 0;
      #1;
      chk("t2_alu", alu_valid, s_fu[i][0]);
      chk("t2_lsq", lsq_valid, s_fu[i][1]);
      chk("t2_bra", bra_valid, s_fu[i][2]);
      chk("t2_pc", out_pc, s_pc[i]);
      chk("t2_fire", rob_alloc_valid, 1);
      step();
    end
    chk("t2_dispatch_cnt", dispatch_cnt, 5);
    chk("t2_stall_cnt", stall_cnt, 0);

    // station back-pressure; a waiting instruction must not overwrite the held one
    present(3'b010, 32'h200, 64'hBEEF);
    step();
    lsq_ready = 0;
    present(3'b001, 32'h300, 64'hCAFE);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_lsq_valid", lsq_valid, 1);
      chk("t3_dec_ready", dec_ready, 0);
      chk("t3_alloc", rob_alloc_valid, 0);
      chk("t3_payload", out_payload, 64'hBEEF);
      step();
    end
    chk("t3_stall_cnt", stall_cnt, 3);
    lsq_ready = 1;
    #1 chk("t3_fire", rob_alloc_valid, 1);
    chk("t3_dec_ready_fire", dec_ready, 1);
    step();
    dec_valid = 0;
    chk("t3_dispatch_cnt", dispatch_cnt, 6);
    chk("t3_next_pc", out_pc, 32'h300);

    // ROB full
    rob_alloc_ready = 0;
    #1 chk("t4_alu_valid", alu_valid, 0);
    chk("t4_alloc", rob_alloc_valid, 0);
    step();
    chk("t4_stall_cnt", stall_cnt, 4);
    rob_alloc_ready = 1;
    #1 chk("t4_alu_resume", alu_valid, 1);
    step();
    chk("t4_dispatch_cnt", dispatch_cnt, 7);

    // illegal drops
    present(3'b001, 32'h111, 64'h1);
    dec_rob_en = 0;
    step();
    dec_valid = 0;
    #1 chk("t5_illegal_cnt", illegal_cnt, 1);
    chk("t5_alu", alu_valid, 0);
    chk("t5_alloc", rob_alloc_valid, 0);
    chk("t5_empty", dec_ready, 1);
    present(3'b011, 32'h222, 64'h2);
    step();
    dec_valid = 0;
    #1 chk("t5_illegal_cnt2", illegal_cnt, 2);
    chk("t5_no_valid", {alu_valid, lsq_valid, bra_valid}, 3'b000);
    chk("t5_dispatch_cnt", dispatch_cnt, 7);

    // flush beats a ready bra
    present(3'b100, 32'h400, 64'h4);
    step();
    dec_valid = 0; flush = 1;
    #1 chk("t6_bra_valid", bra_valid, 0);
    chk("t6_alloc", rob_alloc_valid, 0);
    chk("t6_dec_ready", dec_ready, 0);
    step();
    flush = 0;
    #1 chk("t6_empty_bra", bra_valid, 0);
    chk("t6_empty_ready", dec_ready, 1);
    chk("t6_dispatch_cnt", dispatch_cnt, 7);
    chk("t6_stall_cnt", stall_cnt, 4);

    // reset in the middle of a stall
    present(3'b001, 32'h500, 64'h5);
    step();
    dec_valid = 0; alu_ready = 0;
    step();
    chk("t7_stall_cnt", stall_cnt, 5);
    rst = 1; alu_ready = 1;
    #1 chk("t7_rst_alu", alu_valid, 0);
    chk("t7_rst_ready", dec_ready, 0);
    step();
    rst = 0;
    #1 chk("t7_dispatch_cnt", dispatch_cnt, 0);
    chk("t7_stall_cnt0", stall_cnt, 0);
    chk("t7_illegal_cnt", illegal_cnt, 0);
    chk("t7_out_pc", out_pc, 0);
    chk("t7_payload", out_payload, 0);
    chk("t7_alu_after", alu_valid, 0);
    chk("t7_ready_after", dec_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dispatch_unit.md
DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 64; width of the opaque decoded-control bundle (OpCode, RegWrite, ImmSel, OpASel, OpBSel, ALUCtrl/MemCtrl/BraCtrl, operands).
REQ-002 SHALL have parameter ROB_TAG_W, default 5; width of the ROB entry tag.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  pipeline flush (branch mispredict/exception).
REQ-007 dec_valid  input  1  decoder presents an instruction.
REQ-008 dec_ready  output  1  dispatch_unit accepts the instruction this cycle.
REQ-009 dec_rob_en  input  1  instruction is valid (decoder ROBWrite_en).
REQ-010 dec_fu_type  input  3  target unit: 3'b001 ALU, 3'b010 LSQ, 3'b100 BRA.
REQ-011 dec_pc  input  32  instruction PC.
REQ-012 dec_payload  input  PAYLOAD_W  decoded control bundle.
REQ-013 rob_alloc_ready  input  1  ROB has a free entry.
REQ-014 rob_alloc_tag  input  ROB_TAG_W  tag of next free ROB entry.
REQ-015 rob_alloc_valid  output  1  allocate ROB entry this cycle.
REQ-016 alu_valid / lsq_valid / bra_valid  output  1 each  offer to that reservation station.
REQ-017 alu_ready / lsq_ready / bra_ready  input  1 each  station can accept.
REQ-018 out_payload, out_pc, out_rob_tag  output  PAYLOAD_W, 32, ROB_TAG_W  shared to all stations.
REQ-019 dispatch_cnt  output  32  instructions dispatched; stall_cnt  output  32  cycles held but not dispatched; illegal_cnt  output  16  dropped invalid instructions.

Function
REQ-020 SHALL have states EMPTY and HELD (one holding register: fu_type, pc, payload).
REQ-021 dec_ready SHALL = !flush && (state==EMPTY || fire).
REQ-022 Accept = dec_valid && dec_ready; valid instruction (dec_rob_en=1, fu_type one-hot) -> captured, state HELD next cycle.
REQ-023 Accepted instruction with dec_rob_en=0 or fu_type not one-hot SHALL be dropped, illegal_cnt +1, no state change.
REQ-024 In HELD, xxx_valid SHALL = (held fu_type selects xxx) && rob_alloc_ready; at most one of alu/lsq/bra_valid high.
REQ-025 fire = selected xxx_valid && xxx_ready; rob_alloc_valid SHALL equal fire.
REQ-026 out_rob_tag SHALL equal rob_alloc_tag combinationally; out_payload/out_pc from holding register.
REQ-027 On fire without new accept -> EMPTY; fire with accept -> stay HELD with new instruction (back-to-back, 1 instr/cycle).
REQ-028 Latency: accept in cycle N -> earliest fire in cycle N+1.
REQ-029 HELD and not fire SHALL increment stall_cnt; fire SHALL increment dispatch_cnt.
REQ-030 Counters SHALL wrap modulo 2^width, no saturation.
REQ-031 Dispatch strictly in program order; held instruction never overwritten before fire.
REQ-032 flush SHALL force EMPTY next cycle, suppress all xxx_valid and rob_alloc_valid that cycle, dec_ready=0; counters unaffected.
REQ-033 flush during a would-be fire: flush wins, no allocation, no count.

Reset
REQ-034 rst SHALL set state EMPTY, all counters 0, holding register 0.
REQ-035 During rst cycle: dec_ready, rob_alloc_valid, alu/lsq/bra_valid SHALL be 0; rst overrides flush and in-flight instruction.

Verification
REQ-036 Reset, then dec_valid=1, fu=001, pc=0x100, rob tag=3, all ready -> cycle+1 alu_valid=1, out_pc=0x100, out_rob_tag=3, rob_alloc_valid=1, dispatch_cnt=1.
REQ-037 Stream of 4 instructions fu=001,010,100,001 all ready -> one fire per cycle, correct valid each, dispatch_cnt=4, stall_cnt=0.
REQ-038 HELD lsq instruction, lsq_ready=0 for 3 cycles -> lsq_valid held, dec_ready=0, stall_cnt=3, payload stable; then ready -> fire.
REQ-039 HELD alu instruction, rob_alloc_ready=0 -> alu_valid=0, rob_alloc_valid=0, stall_cnt increments.
REQ-040 dec_rob_en=0 or fu=011 accepted -> no valid output, illegal_cnt=1, state EMPTY.
REQ-041 flush asserted with HELD bra instruction and bra_ready=1 -> bra_valid=0, no allocation, EMPTY next cycle; rst mid-stall -> all outputs/counters 0.
